// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one MIPS load/store at a time to a word-addressed RAM,
// with alignment checking, ack timeout, lane replication and load extension.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_timeout,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic        r_signed;
    logic        r_to;
    logic [1:0]  r_size;
    logic [1:0]  r_off;

    logic        w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_mis  = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) ||
                    (i_size == 2'b10 && i_addr[1:0] != 2'b00);
    // Loads never assert byte enables; only stores select lanes.
    assign w_be   = !i_we ? 4'b0000 :
                    i_size == 2'b00 ? 4'b0001 << i_addr[1:0] :
                    i_size == 2'b01 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wrep = i_size == 2'b00 ? {4{i_wdata[7:0]}} :
                    i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    assign w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    assign w_ext  = r_size == 2'b00 ? {{24{r_signed & w_byte[7]}}, w_byte} :
                    r_size == 2'b01 ? {{16{r_signed & w_half[15]}}, w_half} : i_mem_rdata;

    assign o_busy       = r_state != IDLE;
    assign o_done       = r_state == RESP || r_state == ERR;
    assign o_misaligned = r_state == ERR;
    assign o_timeout    = r_state == RESP && r_to;
    assign o_mem_req    = r_state == ACCESS;
    assign o_mem_we     = r_state == ACCESS && r_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_to        <= 1'b0;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            o_rdata     <= 32'd0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (i_req) begin
                    r_we     <= i_we;
                    r_size   <= i_size;
                    r_signed <= i_signed;
                    r_off    <= i_addr[1:0];
                    r_cnt    <= 8'd0;
                    r_to     <= 1'b0;
                    if (w_mis) begin
                        r_state <= ERR;
                    end else begin
                        r_state     <= ACCESS;
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_be    <= w_be;
                        o_mem_wdata <= w_wrep;
                    end
                end
                ACCESS: if (i_mem_ack) begin
                    if (!r_we) o_rdata <= w_ext;
                    r_state <= RESP;
                end else if (r_cnt == LAST) begin
                    r_to    <= 1'b1;
                    r_state <= RESP;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized loads/stores checked against a
// behavioural model of extension, lane selection, latency and timeout.
module tb_mem_access_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        i_rst_n, i_req, i_we, i_signed, i_mem_ack;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata, i_mem_rdata;
    logic        o_busy, o_done, o_misaligned, o_timeout, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = 32'd0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_size(i_size),
        .i_signed(i_signed), .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy),
        .o_done(o_done), .o_rdata(o_rdata), .o_misaligned(o_misaligned),
        .o_timeout(o_timeout), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: request in IDLE, RAM acks after `delay` request cycles (>= TO means never).
    task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int delay, input logic hold);
        logic mis, acked;
        logic [3:0] be;
        logic [31:0] rep, v;
        int off, n;
        off = int'(addr[1:0]);
        mis = size == 2'd3 || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
        be  = !we ? 4'd0 : size == 2'd0 ? 4'(1 << off) : size == 2'd1 ? 4'(3 << off) : 4'hF;
        rep = size == 2'd0 ? (wd & 32'hFF) * 32'h01010101 :
              size == 2'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        v = rd >> (8 * off);
        v = size == 2'd0 ? (sgn && v[7]  ? v | 32'hFFFFFF00 : v & 32'hFF) :
            size == 2'd1 ? (sgn && v[15] ? v | 32'hFFFF0000 : v & 32'hFFFF) : rd;
        @(negedge clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        i_req = 1; i_we = we; i_size = size; i_signed = sgn; i_addr = addr; i_wdata = wd;
        @(posedge clk);
        if (mis) begin
            @(negedge clk);
            chk("mis_done", o_done, 1);
            chk("mis_flag", o_misaligned, 1);
            chk("mis_req", o_mem_req, 0);
            chk("mis_rdata", o_rdata, model_rdata);
        end else begin
            acked = 0;
            n = 0;
            while (!acked && n < TO) begin
                @(negedge clk);
                chk("acc_req", o_mem_req, 1);
                chk("acc_done", o_done, 0);
                if (n == 0) begin
                    chk("acc_addr", o_mem_addr, addr & 32'hFFFFFFFC);
                    chk("acc_be", o_mem_be, be);
                    chk("acc_we", o_mem_we, we);
                    if (we) chk("acc_wdata", o_mem_wdata, rep);
                end
                i_mem_ack = n == delay;
                i_mem_rdata = rd;
                @(posedge clk);
                acked = i_mem_ack;
                n++;
            end
            @(negedge clk);
            i_mem_ack = 0;
            if (acked && !we) model_rdata = v;
            chk("resp_done", o_done, 1);
            chk("resp_timeout", o_timeout, !acked);
            chk("resp_mis", o_misaligned, 0);
            chk("resp_req", o_mem_req, 0);
            chk("resp_rdata", o_rdata, model_rdata);
        end
        if (!hold) i_req = 0;
    endtask

    initial begin
        i_rst_n = 0; i_req = 0; i_we = 0; i_size = 0; i_signed = 0;
        i_addr = 0; i_wdata = 0; i_mem_ack = 0; i_mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_be", o_mem_be, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        i_rst_n = 1;

        access(0, 2'd0, 0, 32'h1003, 0, 32'h80FF7F01, 0, 0);
        chk("lbu", o_rdata, 32'h00000080);
        access(0, 2'd0, 1, 32'h1003, 0, 32'h80FF7F01, 0, 0);
        chk("lb", o_rdata, 32'hFFFFFF80);
        access(0, 2'd1, 1, 32'h1002, 0, 32'h80FF7F01, 1, 0);
        chk("lh", o_rdata, 32'hFFFF80FF);
        access(0, 2'd1, 0, 32'h1000, 0, 32'h80FF7F01, 2, 0);
        chk("lhu", o_rdata, 32'h00007F01);
        access(1, 2'd0, 0, 32'h2001, 32'h12345678, 32'hDEADBEEF, 0, 0);
        chk("sb_keeps_rdata", o_rdata, 32'h00007F01);
        access(1, 2'd1, 0, 32'h2002, 32'h12345678, 0, 0, 0);
        access(0, 2'd2, 0, 32'h3002, 0, 0, 0, 0);
        access(0, 2'd1, 1, 32'h3001, 0, 0, 0, 0);
        access(1, 2'd3, 0, 32'h3000, 0, 0, 0, 0);
        access(0, 2'd2, 0, 32'h3000, 0, 32'hCAFEF00D, 99, 0);
        chk("timeout_rdata", o_rdata, 32'h00007F01);
        access(0, 2'd2, 0, 32'h3000, 0, 32'hCAFEF00D, TO - 1, 0);
        chk("ack_last_cycle", o_rdata, 32'hCAFEF00D);

        // Request held through a 3-wait access must only be re-accepted from IDLE.
        access(0, 2'd2, 0, 32'h5000, 0, 32'h11223344, 3, 1);
        @(negedge clk);
        chk("hold_idle_busy", o_busy, 0);
        chk("hold_idle_req", o_mem_req, 0);
        @(negedge clk);
        chk("hold_accept", o_mem_req, 1);
        i_mem_ack = 1; i_mem_rdata = 32'h55667788;
        @(negedge clk);
        i_mem_ack = 0; i_req = 0;
        model_rdata = 32'h55667788;
        chk("hold_done", o_done, 1);
        chk("hold_rdata", o_rdata, model_rdata);

        for (int k = 0; k < 60; k++)
            access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 5)), 0);

        @(negedge clk);
        i_req = 1; i_we = 0; i_size = 2'd2; i_addr = 32'h4000;
        @(negedge clk);
        chk("pre_rst_req", o_mem_req, 1);
        i_req = 0;
        #2 i_rst_n = 0;
        #1;
        model_rdata = 0;
        chk("arst_req", o_mem_req, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_rdata", o_rdata, 0);
        chk("arst_addr", o_mem_addr, 0);
        @(negedge clk);
        i_rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_done", o_done, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
